// File: rtl/ula_mc_pkg.sv
// ula_mc_pkg: shared definitions for the multi-cycle ALU (ula_mc).
//   - opcode constants (6-bit encodings of Modo_Funcao_UC)
//   - FSM state encoding
//   - shamt_w(): shift-amount / iteration-counter width derived from WIDTH
package ula_mc_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_MULT = 6'b000010;
  localparam logic [5:0] OP_DIV  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000100;
  localparam logic [5:0] OP_OR   = 6'b000101;
  localparam logic [5:0] OP_NOT  = 6'b000110;
  localparam logic [5:0] OP_XOR  = 6'b000111;
  localparam logic [5:0] OP_SHR  = 6'b001000;
  localparam logic [5:0] OP_SHL  = 6'b001001;
  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNE  = 6'b001011;
  localparam logic [5:0] OP_BLE  = 6'b001100;
  localparam logic [5:0] OP_BGR  = 6'b001101;
  localparam logic [5:0] OP_ADDI = 6'b010000;
  localparam logic [5:0] OP_SUBI = 6'b010001;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    CALC   = 2'b01,
    FIM    = 2'b10
  } estado_t;

  // Bits needed to index a bit position of a WIDTH-bit word.
  function automatic int shamt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ula_mc_iter.sv
// ula_mc_iter: iterative MULT/DIV datapath, one step per clock.
//   MULT: shift-add, acc += a (when b[0]), a <<= 1, b >>= 1.
//   DIV : restoring division; a shifts out the dividend and collects the
//         quotient, acc holds the partial remainder, b holds the divisor.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load            capture operands and clear the counter
//   div_sel         1 = division, 0 = multiplication (captured on load)
//   op_a, op_b      operands captured on load
//   step            perform one iteration
//   last            current step is the final (WIDTH-th) iteration
//   res             result as it will be after the current step
//   rem             remainder after the current step (ULA_MC_RESTO_EN only)
module ula_mc_iter
  import ula_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] res
`ifdef ULA_MC_RESTO_EN
  ,
  output logic [WIDTH-1:0] rem
`endif
);

  localparam int CW = shamt_w(WIDTH);

  logic [CW-1:0]    cnt_r;
  logic             div_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;

  logic [WIDTH-1:0] mul_acc_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] quo_nxt_s;

  // Next-step values for both algorithms.
  always_comb begin
    mul_acc_s = acc_r + (b_r[0] ? a_r : {WIDTH{1'b0}});
    rem_sh_s  = {acc_r, a_r[WIDTH-1]};
    diff_s    = rem_sh_s - {1'b0, b_r};
    // No borrow out of the subtraction means the divisor fits.
    q_bit_s   = ~diff_s[WIDTH];
    if (q_bit_s) begin
      rem_nxt_s = diff_s[WIDTH-1:0];
    end else begin
      rem_nxt_s = rem_sh_s[WIDTH-1:0];
    end
    quo_nxt_s = {a_r[WIDTH-2:0], q_bit_s};
    if (div_r) begin
      res = quo_nxt_s;
    end else begin
      res = mul_acc_s;
    end
`ifdef ULA_MC_RESTO_EN
    rem = rem_nxt_s;
`endif
    last = (cnt_r == CW'(WIDTH - 1));
  end

  // Operand capture and one iteration per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
      div_r <= 1'b0;
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      acc_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= {CW{1'b0}};
      div_r <= div_sel;
      a_r   <= op_a;
      b_r   <= op_b;
      acc_r <= {WIDTH{1'b0}};
    end else if (step) begin
      cnt_r <= cnt_r + CW'(1'b1);
      if (div_r) begin
        acc_r <= rem_nxt_s;
        a_r   <= quo_nxt_s;
      end else begin
        acc_r <= mul_acc_s;
        a_r   <= {a_r[WIDTH-2:0], 1'b0};
        b_r   <= {1'b0, b_r[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/ula_mc.sv
// ula_mc: multi-cycle ALU. Single-cycle ops complete one cycle after the
// accepted start; MULT/DIV run WIDTH iterations in ula_mc_iter.
// Optional feature: define ULA_MC_RESTO_EN to add the Resto (remainder) output.
// Ports:
//   Clock, Reset_n       clock, async active-low reset
//   Inicio               start request (accepted only while idle)
//   Modo_Funcao_UC       opcode
//   L1, Multiplexador_ULA operands A, B
//   Result               registered result
//   Sinal_Desvio         registered branch-taken flag
//   Ocupado              busy (state not OCIOSO)
//   Pronto               one-cycle completion pulse
//   Div_Zero             DIV by zero flag
//   Resto                DIV remainder (ULA_MC_RESTO_EN only)
module ula_mc
  import ula_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Inicio,
  input  logic [OPW-1:0]   Modo_Funcao_UC,
  input  logic [WIDTH-1:0] L1,
  input  logic [WIDTH-1:0] Multiplexador_ULA,
  output logic [WIDTH-1:0] Result,
  output logic             Sinal_Desvio,
  output logic             Ocupado,
  output logic             Pronto,
  output logic             Div_Zero
`ifdef ULA_MC_RESTO_EN
  ,
  output logic [WIDTH-1:0] Resto
`endif
);

  localparam int SW = shamt_w(WIDTH);

  estado_t          estado_r;
  estado_t          estado_nxt_s;
  logic             start_s;
  logic             is_iter_s;
  logic             is_div_s;
  logic             ocupado_s;
  logic             pronto_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_br_s;
  logic             iter_last_s;
  logic [WIDTH-1:0] iter_res_s;
  logic             is_div_r;
  logic             b_zero_r;
  logic [WIDTH-1:0] result_r;
  logic             desvio_r;
  logic             div_zero_r;
  logic             ocupado_r;
  logic             pronto_r;
`ifdef ULA_MC_RESTO_EN
  logic [WIDTH-1:0] iter_rem_s;
  logic [WIDTH-1:0] resto_r;
`endif

  assign start_s   = (estado_r == OCIOSO) && Inicio;
  assign is_div_s  = (Modo_Funcao_UC == OPW'(OP_DIV));
  assign is_iter_s = (Modo_Funcao_UC == OPW'(OP_MULT)) || is_div_s;

  ula_mc_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .load    (start_s && is_iter_s),
    .div_sel (is_div_s),
    .op_a    (L1),
    .op_b    (Multiplexador_ULA),
    .step    (estado_r == CALC),
    .last    (iter_last_s),
    .res     (iter_res_s)
`ifdef ULA_MC_RESTO_EN
    ,
    .rem     (iter_rem_s)
`endif
  );

  // FSM state register plus registered status outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_r  <= OCIOSO;
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
    end else begin
      estado_r  <= estado_nxt_s;
      ocupado_r <= ocupado_s;
      pronto_r  <= pronto_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    estado_nxt_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (start_s) begin
          estado_nxt_s = is_iter_s ? CALC : FIM;
        end else begin
          estado_nxt_s = OCIOSO;
        end
      end
      CALC: begin
        if (iter_last_s) begin
          estado_nxt_s = FIM;
        end else begin
          estado_nxt_s = CALC;
        end
      end
      FIM:     estado_nxt_s = OCIOSO;
      default: estado_nxt_s = OCIOSO;
    endcase
  end

  // FSM outputs, computed from the next state so the registers track the state.
  always_comb begin
    ocupado_s = (estado_nxt_s != OCIOSO);
    pronto_s  = (estado_nxt_s == FIM);
  end

  // Single-cycle operations evaluated on the live operands at the start edge.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_br_s  = 1'b0;
    case (Modo_Funcao_UC)
      OPW'(OP_ADD), OPW'(OP_ADDI): alu_res_s = L1 + Multiplexador_ULA;
      OPW'(OP_SUB), OPW'(OP_SUBI): alu_res_s = L1 - Multiplexador_ULA;
      OPW'(OP_AND): alu_res_s = L1 & Multiplexador_ULA;
      OPW'(OP_OR):  alu_res_s = L1 | Multiplexador_ULA;
      OPW'(OP_NOT): alu_res_s = ~L1;
      OPW'(OP_XOR): alu_res_s = L1 ^ Multiplexador_ULA;
      OPW'(OP_SHR): alu_res_s = L1 >> Multiplexador_ULA[SW-1:0];
      OPW'(OP_SHL): alu_res_s = L1 << Multiplexador_ULA[SW-1:0];
      OPW'(OP_BEQ): alu_br_s  = (L1 == Multiplexador_ULA);
      OPW'(OP_BNE): alu_br_s  = (L1 != Multiplexador_ULA);
      OPW'(OP_BLE): alu_br_s  = (L1 <  Multiplexador_ULA);
      OPW'(OP_BGR): alu_br_s  = (L1 >  Multiplexador_ULA);
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_br_s  = 1'b0;
      end
    endcase
  end

  // Result registers: load at completion, hold otherwise.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      is_div_r   <= 1'b0;
      b_zero_r   <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      desvio_r   <= 1'b0;
      div_zero_r <= 1'b0;
`ifdef ULA_MC_RESTO_EN
      resto_r    <= {WIDTH{1'b0}};
`endif
    end else if (start_s) begin
      is_div_r   <= is_div_s;
      b_zero_r   <= (Multiplexador_ULA == {WIDTH{1'b0}});
      div_zero_r <= 1'b0;
      // Single-cycle ops finish at this very edge; MULT/DIV keep old results.
      if (!is_iter_s) begin
        result_r <= alu_res_s;
        desvio_r <= alu_br_s;
`ifdef ULA_MC_RESTO_EN
        resto_r  <= {WIDTH{1'b0}};
`endif
      end
    end else if ((estado_r == CALC) && iter_last_s) begin
      // Division by zero yields all-ones naturally from restoring division.
      result_r   <= iter_res_s;
      desvio_r   <= 1'b0;
      div_zero_r <= is_div_r && b_zero_r;
`ifdef ULA_MC_RESTO_EN
      resto_r    <= is_div_r ? iter_rem_s : {WIDTH{1'b0}};
`endif
    end
  end

  assign Result       = result_r;
  assign Sinal_Desvio = desvio_r;
  assign Ocupado      = ocupado_r;
  assign Pronto       = pronto_r;
  assign Div_Zero     = div_zero_r;
`ifdef ULA_MC_RESTO_EN
  assign Resto        = resto_r;
`endif

endmodule
